// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Generates the PC, fetches from instruction memory over a req/ack handshake
// and presents each fetched instruction to decode over a valid/ready handshake.
// A one-cycle redirect from execute discards whatever is in flight or held and
// restarts fetching at the (word-aligned) target.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   imem_req     fetch request, held with stable imem_addr until imem_ack
//   imem_addr    word-aligned fetch address
//   imem_ack     memory response, only honoured while imem_req=1
//   imem_rdata   instruction word returned with imem_ack
//   instr_valid  instr/instr_pc hold a fetched instruction
//   instr_ready  decode accepts the instruction when high with instr_valid
//   instr        fetched instruction (NOP_INSTR when nothing is held)
//   instr_pc     address of instr
//   redirect     one-cycle pulse: restart fetching at redirect_pc
//   redirect_pc  redirect target, low two bits ignored
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    // FETCH: request outstanding for pc. HOLD: instruction presented to decode.
    // DISCARD: a redirect arrived mid-request; drain the stale ack first.
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_instr_valid;

    state_t          w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_req_addr_nxt;
    logic [XLEN-1:0] w_instr_nxt;
    logic [XLEN-1:0] w_instr_pc_nxt;
    logic            w_instr_valid_nxt;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_ack;

    assign w_redirect_pc = redirect_pc & ALIGN_MASK;
    assign w_ack         = imem_req & imem_ack;

    // Request is a pure function of state so it can never be withdrawn early.
    assign imem_req    = ~rst & (r_state != S_HOLD);
    assign imem_addr   = r_req_addr;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

    // Next-state logic; redirect takes priority in every state.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = r_instr_valid;

        unique case (r_state)
            S_FETCH: begin
                if (redirect) begin
                    w_pc_nxt = w_redirect_pc;
                    // Without an ack the request must stay up on the old address.
                    if (!w_ack) begin
                        w_state_nxt = S_DISCARD;
                    end
                end else if (w_ack) begin
                    w_instr_nxt       = imem_rdata;
                    w_instr_pc_nxt    = r_pc;
                    w_instr_valid_nxt = 1'b1;
                    w_pc_nxt          = r_pc + PC_STEP;
                    w_state_nxt       = S_HOLD;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    w_pc_nxt = w_redirect_pc;
                end
                if (w_ack) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_pc_nxt = w_redirect_pc;
                end
                if (redirect || instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    w_instr_nxt       = NOP_INSTR;
                    w_state_nxt       = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase

        // A new request always starts on the updated pc.
        w_req_addr_nxt = (w_state_nxt == S_FETCH) ? w_pc_nxt : r_req_addr;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_req_addr    <= w_req_addr_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit. The reference model is the
// architectural instruction stream: after reset the next instruction is at
// RESET_PC, each consumed instruction advances it by 4, a redirect replaces it.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    instr_fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    bit   started;
    bit   fast_chk;
    bit   poison;
    int   wmin, wmax, wait_tgt, waited;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory image: distinct, recognisable word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy);
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        instr_ready = rdy;
        #1;
        if (imem_req) begin
            if (waited >= wait_tgt) begin
                imem_ack   = 1'b1;
                imem_rdata = poison ? 32'hDEAD_BEEF : mem_word(imem_addr);
                waited     = 0;
                wait_tgt   = $urandom_range(wmax, wmin);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                waited++;
            end
        end else begin
            // Spurious acks while no request is up must be ignored.
            waited     = 0;
            imem_ack   = 1'($urandom_range(1, 0));
            imem_rdata = $urandom;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_wait(input int lo, input int hi);
        wmin     = lo;
        wmax     = hi;
        wait_tgt = lo;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(3, 0) != 0) t = t & 32'h0000_03FF;
        return t;
    endfunction

    task automatic run_random(input int n, input int rst_pm, input int rd_pct, input int rdy_pct);
        for (int i = 0; i < n; i++) begin
            step(($urandom_range(999, 0) < rst_pm),
                 ($urandom_range(99, 0) < rd_pct),
                 rand_target(),
                 ($urandom_range(99, 0) < rdy_pct));
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 50 && !instr_valid; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        if (!instr_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: instr_valid still %b, required 1", nm, instr_valid);
        end
    endtask

    // Monitor: samples at negedge and predicts the effect of the next posedge.
    initial begin : monitor
        logic        p_req, p_ack_taken, p_redir, p_rst;
        logic [31:0] p_addr;
        int          cyc, idle;
        exp_t        e;
        p_req = 1'b0; p_ack_taken = 1'b0; p_redir = 1'b0; p_rst = 1'b0;
        p_addr = '0; cyc = 0; idle = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("req_low_in_rst", 32'(imem_req), 32'd0);
                if (p_rst) begin
                    chk("rst_valid", 32'(instr_valid), 32'd0);
                    chk("rst_instr", instr, NOP);
                    chk("rst_instr_pc", instr_pc, 32'd0);
                    chk("rst_addr", imem_addr, RESET_PC);
                end
                exp_q.delete();
                exp_q.push_back('{RESET_PC, mem_word(RESET_PC)});
                started = 1'b1;
                cyc     = 0;
                idle    = 0;
            end else if (started) begin
                cyc++;
                if (fast_chk) chk("throughput_valid", 32'(instr_valid), 32'((cyc % 2) == 0));
                if (p_redir && !p_rst) chk("valid_after_redirect", 32'(instr_valid), 32'd0);
                if (instr_valid) begin
                    idle = 0;
                    chk("no_req_while_holding", 32'(imem_req), 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_delivery", instr_pc, 32'hFFFF_FFFF);
                    end else begin
                        chk("instr_pc", instr_pc, exp_q[0].pc);
                        chk("instr", instr, exp_q[0].ins);
                    end
                end else begin
                    idle++;
                    chk("nop_when_invalid", instr, NOP);
                end
                if (imem_req) begin
                    chk("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
                    if (!p_req || p_ack_taken) begin
                        if (exp_q.size() != 0) chk("new_req_addr", imem_addr, exp_q[0].pc);
                    end else begin
                        chk("req_addr_stable", imem_addr, p_addr);
                    end
                end
                if (idle > 100) begin
                    chk("progress_watchdog", 32'(instr_valid), 32'd1);
                    idle = 0;
                end
                // Advance the architectural stream for the coming edge.
                if (instr_valid && instr_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    exp_q.push_back('{e.pc + 32'd4, mem_word(e.pc + 32'd4)});
                end
                if (redirect) begin
                    exp_q.delete();
                    exp_q.push_back('{redirect_pc & 32'hFFFF_FFFC,
                                      mem_word(redirect_pc & 32'hFFFF_FFFC)});
                end
            end
            p_req       = imem_req;
            p_ack_taken = imem_req && imem_ack;
            p_redir     = redirect;
            p_rst       = rst;
            p_addr      = imem_addr;
        end
    end

    initial begin : driver
        n_vec = 0; n_err = 0; started = 1'b0; fast_chk = 1'b0; poison = 1'b0;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; waited = 0;
        set_wait(0, 0);
        @(posedge clk);
        #1;

        // Zero-wait memory, ready held: one instruction every two cycles.
        fast_chk = 1'b1;
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        fast_chk = 1'b0;

        // Three-cycle memory latency at 0x10, then decode stalls in HOLD.
        set_wait(3, 3);
        step(1'b0, 1'b1, 32'h0000_0010, 1'b0);
        wait_valid("fetch_0x10");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect mid-request; the stale ack carries a poisoned word.
        do_reset();
        set_wait(2, 2);
        poison = 1'b1;
        step(1'b0, 1'b1, 32'h0000_0203, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        poison = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect and ready together while holding an instruction.
        set_wait(0, 2);
        wait_valid("hold_before_redirect");
        step(1'b0, 1'b1, rand_target(), 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Address wrap at the top of memory, then reset mid-request.
        set_wait(0, 0);
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h0); i++)
            step(1'b0, 1'b0, 32'h0, 1'b1);
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Long random run.
        set_wait(0, 3);
        run_random(3000, 3, 8, 70);
        run_random(20, 0, 0, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer end of the instruction interface: generates the PC, fetches from instruction memory over a req/ack handshake, and presents each instruction to the decode/control logic over a valid/ready handshake.
- Accepts a one-cycle redirect (taken branch/jump target) from execute.
- Sits between imem and the control unit / register-file decode stage.

Parameters:
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- imem_req  output  1  fetch request; held high with stable imem_addr until imem_ack.
- imem_addr  output  XLEN  word-aligned fetch address.
- imem_ack  input  1  memory response; valid only while imem_req=1, may assert in the same cycle req rises.
- imem_rdata  input  XLEN  instruction word, valid when imem_ack=1.
- instr_valid  output  1  instr/instr_pc hold a fetched instruction.
- instr_ready  input  1  decode accepts instruction when high with instr_valid.
- instr  output  XLEN  fetched instruction.
- instr_pc  output  XLEN  address of instr.
- redirect  input  1  one-cycle pulse: discard in-flight/held fetch, restart at redirect_pc.
- redirect_pc  input  XLEN  redirect target; bits [1:0] forced to 0 internally.

Behaviour:
- Registered state: pc, req_addr, FSM state in {FETCH, HOLD, DISCARD}, instr, instr_pc, instr_valid.
- Reset (rst=1 at an edge), overrides everything including mid-handshake:
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=NOP_INSTR, instr_pc=0.
- imem_req is combinational from state: 1 in FETCH and DISCARD, 0 in HOLD and while rst=1. imem_addr = req_addr.
- imem_ack is ignored whenever imem_req=0.
- FETCH:
  - req_addr=pc.
  - ack with no redirect: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2^XLEN, 32'hFFFF_FFFC wraps to 0), state<=HOLD.
  - ack with redirect in the same cycle: data dropped, pc<=redirect_pc, stay FETCH.
  - redirect without ack: pc<=redirect_pc, state<=DISCARD; req and old req_addr stay held, since the memory protocol forbids withdrawing a request.
- DISCARD:
  - req held on the old address.
  - ack: data dropped, state<=FETCH, req_addr<=pc.
  - Further redirects overwrite pc; the last one wins.
- HOLD:
  - instr_valid=1; instr and instr_pc stay stable while instr_ready=0.
  - instr_ready=1 without redirect: instr_valid<=0, instr<=NOP_INSTR, state<=FETCH, req_addr<=pc.
  - redirect: instr_valid<=0, instr<=NOP_INSTR, pc<=redirect_pc, state<=FETCH. If instr_ready=1 in the same cycle, that handshake still counts as consumed.
- Timing:
  - Latency: ack at edge N gives instr_valid=1 from cycle N+1.
  - Back-to-back with zero-wait memory and ready held high: one instruction every 2 cycles.
  - Redirect-to-first-request latency is 1 cycle, unless a DISCARD drain is required.
- redirect has priority over every other event in every state.

Test Plan:
- Reset release, RESET_PC=0, imem acks same cycle, ready=1 → imem_addr sequence 0,4,8,12; instr_pc matches; instr_valid high on every other cycle; first instr_valid cycle 2 after rst falls.
- Memory ack delayed 3 cycles at addr 0x10 → imem_req and imem_addr=0x10 stable for all 4 cycles; instr=rdata captured; instr_pc=0x10.
- instr_ready=0 for 5 cycles in HOLD with instr=0x00500093 → instr, instr_pc, instr_valid unchanged; no imem_req; on ready, the next fetch goes to instr_pc+4.
- redirect to 0x0000_0203 during FETCH, ack 2 cycles later with 0xDEADBEEF → 0xDEADBEEF never appears with instr_valid=1; next imem_addr=0x200; the 0x200 instruction is delivered.
- redirect and instr_ready together in HOLD → instr_valid=0 next cycle; next imem_addr=redirect_pc; no duplicate delivery.
- pc=0xFFFF_FFFC fetched, then rst asserted while imem_req is high → next fetch would be addr 0 (wrap); during rst, imem_req=0 and instr_valid=0; a late ack is ignored; after rst the first imem_addr=RESET_PC.
